// File: rtl/inst_loader_pkg.sv
// Shared definitions for the program loader / instruction store.
//   INST_ADDR_WIDTH : default word-address width (capacity 2^15 words)
//   loader_state_t  : loader FSM state encoding
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds the CHK state.
package constant;

  localparam int INST_ADDR_WIDTH = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Bundle of the loader's byte-input, fetch and status signals.
//   start, rx_data, rx_valid, pc : driven by the CPU top / uart_rx side
//   inst, busy, done, err        : driven by the loader
//   state                        : loader FSM state, exposed for debug
// Byte handshake: rx_valid is a one-cycle qualifier per byte with no
// back-pressure; the loader accepts a byte on every cycle rx_valid is high
// and it is in a state that consumes bytes, otherwise the byte is dropped.
interface inst_loader_if;
  import constant::*;

  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          busy;
  logic          done;
  logic          err;
  loader_state_t state;

  modport master (
    output start, rx_data, rx_valid, pc,
    input  inst, busy, done, err, state
  );

  modport slave (
    input  start, rx_data, rx_valid, pc,
    output inst, busy, done, err, state
  );

endinterface

// File: rtl/inst_ram.sv
// Simple dual-port instruction RAM: one write port, one registered
// read-first read port. Storage has no reset; only the read register
// resets to zero.
//   clk, rst      : clock, synchronous active-high reset of rdata
//   we/waddr/wdata: write port
//   raddr/rdata   : read port, one-cycle latency
module inst_ram
  import constant::*;
#(
  parameter int ADDR_WIDTH = INST_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the same array gives read-first behaviour on a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_loader.sv
// Program loader and instruction store. In load mode assembles big-endian
// words from a byte stream (4-byte word count, then the words) into the
// instruction RAM; at all times returns ram[pc] one cycle later on inst.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_loader_if slave (start, rx_*, pc in; inst, busy, done,
//              err, state out)
// Optional feature: define INST_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over all data bytes before reporting done.
module inst_loader
  import constant::*;
#(
  parameter int ADDR_WIDTH = INST_ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  inst_loader_if.slave bus
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  loader_state_t         state;
  logic [1:0]            byte_cnt;
  logic [31:0]           len;
  logic [23:0]           shift;
  logic [ADDR_WIDTH:0]   waddr;   // one extra bit so N = 2^ADDR_WIDTH ends cleanly
  logic                  busy;
  logic                  done;
  logic                  err;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic [31:0] len_next;
  logic [31:0] word_next;
  logic        we;
  logic        last_word;

  assign len_next  = {len[23:0], bus.rx_data};
  assign word_next = {shift, bus.rx_data};
  // The word completes on the same edge as its 4th byte.
  assign we        = (state == ST_DATA) && bus.rx_valid && (byte_cnt == 2'd3);
  assign last_word = ((32'(waddr) + 32'd1) == len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      len      <= '0;
      shift    <= '0;
      waddr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // Bytes arriving here (including one coinciding with start) drop.
          if (bus.start) begin
            state    <= ST_LEN;
            byte_cnt <= '0;
            len      <= '0;
            waddr    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (bus.rx_valid) begin
            len      <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_next == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state <= ST_CHK;
`else
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end else if ({1'b0, len_next} > MAX_WORDS) begin
                state <= ST_ERROR;
                busy  <= 1'b0;
                err   <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (bus.rx_valid) begin
            shift    <= word_next[23:0];
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              waddr <= waddr + 1'b1;
              if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state <= ST_CHK;
`else
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (bus.rx_valid) begin
            busy <= 1'b0;
            if (bus.rx_data == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  inst_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr[ADDR_WIDTH-1:0]),
    .wdata (word_next),
    .raddr (bus.pc[ADDR_WIDTH+1:2]),
    .rdata (bus.inst)
  );

  // Byte offset and bits above the RAM depth are don't-care (address wraps).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc[1:0], bus.pc[31:ADDR_WIDTH+2]};

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.err   = err;
  assign bus.state = state;

endmodule
